// File: rtl/stack_pkg.sv
// Shared definitions for the operand stack: default geometry, count sizing
// and the per-cycle action encoding used by the decoder.
package stack_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // The count must be able to represent DEPTH itself, hence one extra bit.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PUSH     = 3'd1,
        POP      = 3'd2,
        TOS      = 3'd3,
        REPLACE  = 3'd4,
        PUSH_TOS = 3'd5
    } action_t;

endpackage

// File: rtl/stack_ram.sv
// Stack storage: DEPTH x WIDTH register file with one synchronous write port
// and one asynchronous read port. Contents are deliberately not reset.
module stack_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stack_unit.sv
// Operand stack for the stack CPU datapath: action decoder, stack pointer,
// sticky error flags and registered top-of-stack read result.
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          tos,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic                          dout_valid,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty,
    output logic                          full,
    output logic                          ovf,
    output logic                          udf,
    input  logic                          clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [CW-1:0]    sp_reg;
    logic [CW-1:0]    sp_next;
    action_t          action;
    logic             is_empty;
    logic             is_full;
    logic             do_read;
    logic             do_write;
    logic             ovf_set;
    logic             udf_set;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] rd_data;

    assign is_empty = (sp_reg == '0);
    assign is_full  = (sp_reg == CW'(DEPTH));
    assign top_addr = AW'(sp_reg - CW'(1));

    // An empty stack demotes any combined read/push to a plain push and a
    // lone read to no action; the underflow flag records the failed read.
    always_comb begin
        action = IDLE;
        if (push && pop) begin
            action = is_empty ? PUSH : REPLACE;
        end else if (pop) begin
            action = is_empty ? IDLE : POP;
        end else if (push && tos) begin
            action = is_empty ? PUSH : PUSH_TOS;
        end else if (push) begin
            action = PUSH;
        end else if (tos) begin
            action = is_empty ? IDLE : TOS;
        end
    end

    always_comb begin
        udf_set  = (pop || tos) && is_empty;
        // Replace keeps sp unchanged, so it can never overflow.
        ovf_set  = push && !pop && is_full;
        do_read  = (action == REPLACE) || (action == POP) ||
                   (action == PUSH_TOS) || (action == TOS);
        do_write = (action == REPLACE) ||
                   (((action == PUSH) || (action == PUSH_TOS)) && !is_full);
        wr_addr  = (action == REPLACE) ? top_addr : sp_reg[AW-1:0];
        sp_next  = sp_reg;
        if (action == POP) begin
            sp_next = sp_reg - CW'(1);
        end else if (((action == PUSH) || (action == PUSH_TOS)) && !is_full) begin
            sp_next = sp_reg + CW'(1);
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (do_write && !rst),
        .waddr (wr_addr),
        .wdata (din),
        .raddr (top_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_reg     <= '0;
            empty      <= 1'b1;
            full       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
        end else begin
            sp_reg     <= sp_next;
            empty      <= (sp_next == '0);
            full       <= (sp_next == CW'(DEPTH));
            dout_valid <= do_read;
            if (do_read) begin
                dout <= rd_data;
            end
            // A new error in the same cycle as clear_err takes precedence.
            ovf <= ovf_set || (ovf && !clear_err);
            udf <= udf_set || (udf && !clear_err);
        end
    end

    assign count = sp_reg;

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack serving the multi-cycle stack CPU's datapath. Responds to the controller's `push`, `pop` and `tos` strobes by storing operands from the datapath and returning the top-of-stack value on a registered output one cycle later. Tracks occupancy, raises full/empty status, and latches sticky overflow/underflow errors for debug.

## Interface
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 16, number of entries (power of two, >= 2)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `push`  input  1  store `din` on top of stack this cycle
- `pop`  input  1  remove top entry; its value appears on `dout` next cycle
- `tos`  input  1  read top entry without removing it
- `din`  input  WIDTH  data to push
- `dout`  output  WIDTH  registered top-of-stack read result
- `dout_valid`  output  1  one-cycle pulse: `dout` updated by a successful read
- `count`  output  $clog2(DEPTH)+1  current number of entries
- `empty`  output  1  `count == 0`
- `full`  output  1  `count == DEPTH`
- `ovf`  output  1  sticky: push attempted while full
- `udf`  output  1  sticky: pop/tos attempted while empty
- `clear_err`  input  1  synchronous clear of `ovf` and `udf`

## Operation
- Internal stack pointer `sp` = `count`; entries at indices 0..sp-1, top at sp-1.
- Per cycle, the strobe combination decides one action, priority in this order:
  - `push`&`pop`, not empty: replace: `dout` <= mem[sp-1], mem[sp-1] <= `din`, sp unchanged, `dout_valid` pulses.
  - `push`&`pop`, empty: `udf` set; push proceeds as plain push; no read.
  - `pop` (with or without `tos`), not empty: `dout` <= mem[sp-1], sp <= sp-1, `dout_valid` pulses.
  - `pop`, empty: `udf` set; sp, `dout` unchanged; no pulse.
  - `push`&`tos`, not empty: `dout` <= old top mem[sp-1]; then mem[sp] <= `din`, sp+1 (if not full, else `ovf`, write dropped, read still happens).
  - `push`&`tos`, empty: `udf` set; push proceeds.
  - `push` alone, not full: mem[sp] <= `din`, sp <= sp+1.
  - `push` alone, full: write dropped, sp unchanged, `ovf` set.
  - `tos` alone: read mem[sp-1] if not empty, else `udf`.
- Replace (`push`&`pop`) never overflows, even when full.
- `clear_err` clears `ovf`/`udf`; if an error occurs the same cycle, the set wins.
- Memory contents not reset; never read outside 0..sp-1.

## Timing
- All outputs registered. `dout`/`dout_valid` reflect the command one cycle after the strobe edge.
- `count`, `empty`, `full` reflect the post-operation state one cycle after the command.
- `dout` holds its last value until the next successful read; `dout_valid` high exactly one cycle per read.
- Back-to-back commands every cycle supported; push then pop next cycle returns the just-pushed value.
- Reset (any time, including mid-sequence): sp=0, `count`=0, `empty`=1, `full`=0, `dout`=0, `dout_valid`=0, `ovf`=0, `udf`=0. Strobes during reset ignored.

## Structure
- Shared package `stack_pkg`: default `WIDTH`/`DEPTH` constants, count-width function, action enum (IDLE, PUSH, POP, TOS, REPLACE, PUSH_TOS) used by the decoder and the bench scoreboard.
- One sub-module `stack_ram`: DEPTH×WIDTH register file, one synchronous write port, one asynchronous read port; no reset on storage.
- Top holds the action decoder, sp counter, error flags and output registers.

## Test plan (WIDTH=8, DEPTH=4)
- Reset, push 0x11,0x22,0x33, pop×3 -> `dout` 0x33,0x22,0x11 with `dout_valid` pulses; `empty`=1 after.
- Push 0xA1..0xA4 -> `full`=1, `count`=4; push 0xA5 -> `ovf`=1, count stays 4; pop -> `dout`=0xA4.
- Pop on empty -> `udf`=1, `dout_valid`=0, `dout` unchanged; `clear_err` -> `udf`=0 next cycle.
- Push 0x05, then `push`&`pop` with `din`=0x09 -> `dout`=0x05, count 1; `tos` -> `dout`=0x09. Repeat when full -> no `ovf`.
- Push 0x10, `push`&`tos` with 0x20 -> `dout`=0x10, count 2; pop -> 0x20.
- Push 0x7F twice, assert `rst` mid-stream -> all outputs at reset values; subsequent pop -> `udf`=1.
